// File: rtl/tdp_ram_bist_ctrl.sv
// Write/read-back self-test controller for an internally inferred true dual-port RAM.
// Both ports fill disjoint regions with an incrementing pattern, then read back and compare.
module tdp_ram_bist_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 7,
    parameter int LEN    = 50,
    parameter int BASE_A = 0,
    parameter int BASE_B = 50,
    parameter int SEED_A = 0,
    parameter int SEED_B = 50,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_w,
    input  logic          start_r,
    input  logic          inject_err,
    output logic [DW-1:0] douta,
    output logic [DW-1:0] doutb,
    output logic          dout_vld,
    output logic          done_w,
    output logic          done_r,
    output logic          busy,
    output logic          pass,
    output logic [AW+1:0] err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT, S_READ, S_DRAIN} state_t;

    localparam logic [AW-1:0] BA    = AW'(BASE_A);
    localparam logic [AW-1:0] BB    = AW'(BASE_B);
    localparam logic [DW-1:0] SA    = DW'(SEED_A);
    localparam logic [DW-1:0] SB    = DW'(SEED_B);
    localparam logic [AW:0]   LAST  = (AW+1)'(LEN - 1);
    localparam logic [AW:0]   DLAST = (AW+1)'(RD_LAT - 1);

    logic [DW-1:0] mem [2**AW];

    state_t          state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d, cmp_q, cmp_d;
    logic [AW+1:0]   err_q, err_d;
    logic            pass_q, pass_d, busy_q, busy_d;
    logic            done_w_q, done_w_d, done_r_q, done_r_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DW-1:0]   ram_a_q, ram_a_d, ram_b_q, ram_b_d;
    logic [DW-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;

    logic            wr, rd, mism_a, mism_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic [DW-1:0]   wdata_a, wdata_b;

    assign wr      = (state_q == S_WRITE);
    assign rd      = (state_q == S_READ);
    assign addr_a  = BA + cnt_q[AW-1:0];
    assign addr_b  = BB + cnt_q[AW-1:0];
    assign wdata_a = (SA + DW'(cnt_q)) ^ DW'(inject_err);
    assign wdata_b = SB + DW'(cnt_q);

    assign douta    = (RD_LAT == 2) ? out_a_q : ram_a_q;
    assign doutb    = (RD_LAT == 2) ? out_b_q : ram_b_q;
    assign dout_vld = vld_q[RD_LAT-1];
    assign done_w   = done_w_q;
    assign done_r   = done_r_q;
    assign busy     = busy_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;

    // Port B write is issued last so it wins when both ports hit one address.
    always_ff @(posedge clk) begin
        if (wr) mem[addr_a] <= wdata_a;
        if (wr) mem[addr_b] <= wdata_b;
    end

    // Expected pattern is rebuilt from a compare-side index, not pipelined from the read side.
    assign mism_a = dout_vld && (douta != SA + DW'(cmp_q));
    assign mism_b = dout_vld && (doutb != SB + DW'(cmp_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        err_d    = err_q;
        pass_d   = pass_q;
        done_w_d = 1'b0;
        done_r_d = 1'b0;
        vld_d    = RD_LAT'({vld_q, rd});
        ram_a_d  = rd ? mem[addr_a] : ram_a_q;
        ram_b_d  = rd ? mem[addr_b] : ram_b_q;
        out_a_d  = ram_a_q;
        out_b_d  = ram_b_q;

        if (dout_vld) begin
            cmp_d = cmp_q + 1'b1;
            err_d = err_q + (AW+2)'(mism_a) + (AW+2)'(mism_b);
        end

        case (state_q)
            S_IDLE: if (start_w) begin
                state_d = S_WRITE;
                cnt_d   = '0;
            end
            S_WRITE: if (cnt_q == LAST) begin
                state_d  = S_WAIT;
                cnt_d    = '0;
                done_w_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            S_WAIT: if (start_r) begin
                state_d = S_READ;
                cnt_d   = '0;
                cmp_d   = '0;
                err_d   = '0;
                pass_d  = 1'b0;
            end
            S_READ: if (cnt_q == LAST) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            S_DRAIN: if (cnt_q == DLAST) begin
                state_d  = S_IDLE;
                done_r_d = 1'b1;
                pass_d   = (err_d == '0);
            end else cnt_d = cnt_q + 1'b1;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmp_q    <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_w_q <= 1'b0;
            done_r_q <= 1'b0;
            vld_q    <= '0;
            ram_a_q  <= '0;
            ram_b_q  <= '0;
            out_a_q  <= '0;
            out_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_w_q <= done_w_d;
            done_r_q <= done_r_d;
            vld_q    <= vld_d;
            ram_a_q  <= ram_a_d;
            ram_b_q  <= ram_b_d;
            out_a_q  <= out_a_d;
            out_b_q  <= out_b_d;
        end
    end
endmodule
